flag_unit: RTL and testbench

- Producer side of the branch-condition interface: generates, pipelines and commits the Z/V/N flag vector that PC_control consumes as F (with Branch/BranchReg) to resolve conditional branches.
- Sits beside the ALU in the 5-stage CPU. Captures flag candidates in EX, holds them in one pending slot (EX/MEM), and commits them to the architectural flag register at the end of MEM.
- Supplies ID-stage branch logic with either forwarded flags or a hazard stall.

---
 rtl/flag_unit.sv | 96 +++++++++
 tb/tb_flag_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// Z/V/N flag producer: captures ALU flag candidates in EX, holds one pending
// writer in EX/MEM, commits to the architectural flags at the end of MEM.
module flag_unit #(
  parameter int FLAG_FWD = 1,
  parameter int DW       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_flush,
  input  logic                 ex_hold,
  input  logic [3:0]           ex_opcode,
  input  logic signed [DW-1:0] alu_result,
  input  logic                 alu_ovfl,
  input  logic                 id_branch,
  output logic [2:0]           F,
  output logic [2:0]           F_id,
  output logic                 flag_stall,
  output logic                 pend_valid
);

  function automatic logic [2:0] wr_mask(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001:                   wr_mask = 3'b111;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: wr_mask = 3'b100;
      default:                            wr_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] overlay(input logic [2:0] base,
                                         input logic [2:0] upd,
                                         input logic [2:0] sel);
    overlay = (base & ~sel) | (upd & sel);
  endfunction

  logic [2:0] ex_mask;
  logic [2:0] ex_cand;
  logic       ex_wr;

  logic [2:0] f_q,          f_d;
  logic       pend_valid_q, pend_valid_d;
  logic [2:0] pend_mask_q,  pend_mask_d;
  logic [2:0] pend_flags_q, pend_flags_d;

  logic [2:0] fwd_flags;
  logic       stall_raw;

  // EX: candidate flags and write enable
  always_comb begin
    ex_mask = wr_mask(ex_opcode);
    ex_cand = {(alu_result == '0), alu_ovfl, alu_result[DW-1]};
    ex_wr   = ex_valid & ~ex_flush & (ex_mask != 3'b000);
  end

  // EX/MEM slot load and MEM commit share the same unheld edge
  always_comb begin
    f_d          = f_q;
    pend_valid_d = pend_valid_q;
    pend_mask_d  = pend_mask_q;
    pend_flags_d = pend_flags_q;
    if (!ex_hold) begin
      pend_valid_d = ex_wr;
      pend_mask_d  = ex_mask;
      pend_flags_d = ex_cand;
      if (pend_valid_q)
        f_d = overlay(f_q, pend_flags_q, pend_mask_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q          <= 3'b000;
      pend_valid_q <= 1'b0;
      pend_mask_q  <= 3'b000;
      pend_flags_q <= 3'b000;
    end else begin
      f_q          <= f_d;
      pend_valid_q <= pend_valid_d;
      pend_mask_q  <= pend_mask_d;
      pend_flags_q <= pend_flags_d;
    end
  end

  // ID: youngest writer wins per bit, EX over pending over committed
  always_comb begin
    fwd_flags = overlay(f_q, pend_flags_q, pend_mask_q & {3{pend_valid_q}});
    fwd_flags = overlay(fwd_flags, ex_cand, ex_mask & {3{ex_wr}});
    stall_raw = id_branch & (ex_wr | pend_valid_q);
  end

  assign F          = f_q;
  assign pend_valid = pend_valid_q;
  assign F_id       = (FLAG_FWD != 0) ? fwd_flags : f_q;
  assign flag_stall = (FLAG_FWD != 0) ? 1'b0 : stall_raw;

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: forwarding and non-forwarding instances share stimulus;
// a per-cycle expected record is queued by the driver and checked by a monitor.
module tb_flag_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_flush = 1'b0, ex_hold = 1'b0;
  logic [3:0]  ex_opcode = 4'd15;
  logic [15:0] alu_result = 16'h0;
  logic        alu_ovfl = 1'b0, id_branch = 1'b0;

  logic [2:0] f1, fid1, f0, fid0;
  logic       st1, st0, pv1, pv0;

  always #5 clk = ~clk;

  flag_unit #(.FLAG_FWD(1), .DW(16)) dut_fwd (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_hold(ex_hold), .ex_opcode(ex_opcode), .alu_result(alu_result),
    .alu_ovfl(alu_ovfl), .id_branch(id_branch), .F(f1), .F_id(fid1),
    .flag_stall(st1), .pend_valid(pv1));

  flag_unit #(.FLAG_FWD(0), .DW(16)) dut_nofwd (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_hold(ex_hold), .ex_opcode(ex_opcode), .alu_result(alu_result),
    .alu_ovfl(alu_ovfl), .id_branch(id_branch), .F(f0), .F_id(fid0),
    .flag_stall(st0), .pend_valid(pv0));

  typedef struct {
    logic [2:0] f, fid0, fid1;
    logic       pv, st0, st1;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: architectural flags plus the one in-flight flag writer.
  logic [2:0] m_f = 3'b000;
  logic       m_pv = 1'b0;
  logic [2:0] m_pm = 3'b000, m_pf = 3'b000;

  function automatic logic [2:0] ref_mask(input int op);
    if (op <= 1) return 3'b111;
    if (op == 2 || (op >= 4 && op <= 6)) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] ref_cand(input logic [15:0] r, input logic ov);
    logic z, n;
    z = (r == 16'd0);
    n = ($signed(r) < 0);
    return {z, ov, n};
  endfunction

  function automatic logic ref_wr();
    return ex_valid && !ex_flush && (ref_mask(int'(ex_opcode)) != 3'b000);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_f = 3'b000; m_pv = 1'b0; m_pm = 3'b000; m_pf = 3'b000;
    end else if (!ex_hold) begin
      if (m_pv)
        for (int b = 0; b < 3; b++) if (m_pm[b]) m_f[b] = m_pf[b];
      m_pv = ref_wr();
      m_pm = ref_mask(int'(ex_opcode));
      m_pf = ref_cand(alu_result, alu_ovfl);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    logic [2:0] mk, cd;
    mk = ref_mask(int'(ex_opcode));
    cd = ref_cand(alu_result, alu_ovfl);
    e.f = m_f; e.pv = m_pv; e.fid0 = m_f; e.st1 = 1'b0;
    e.st0 = id_branch && (ref_wr() || m_pv);
    for (int b = 0; b < 3; b++) begin
      if (ref_wr() && mk[b])     e.fid1[b] = cd[b];
      else if (m_pv && m_pm[b])  e.fid1[b] = m_pf[b];
      else                       e.fid1[b] = m_f[b];
    end
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic fl, input logic h,
                      input logic [3:0] op, input logic [15:0] res,
                      input logic ov, input logic br);
    @(posedge clk);
    model_edge();
    #1;
    rst = r; ex_valid = v; ex_flush = fl; ex_hold = h;
    ex_opcode = op; alu_result = res; alu_ovfl = ov; id_branch = br;
    push_expected();
  endtask

  task automatic idle(input logic br);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 16'h1234, 1'b0, br);
  endtask

  // Monitor: compares every queued record mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("F_fwd",       f1,          e.f);
        check("F_nofwd",     f0,          e.f);
        check("pend_fwd",    {2'b0, pv1}, {2'b0, e.pv});
        check("pend_nofwd",  {2'b0, pv0}, {2'b0, e.pv});
        check("F_id_fwd",    fid1,        e.fid1);
        check("F_id_nofwd",  fid0,        e.fid0);
        check("stall_fwd",   {2'b0, st1}, {2'b0, e.st1});
        check("stall_nofwd", {2'b0, st0}, {2'b0, e.st0});
      end
    end
  end

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 16'h0, 1'b0, 1'b0);
    idle(1'b0);
    at_neg();
    check("reset_F", f1, 3'b000);
    check("reset_pend", {2'b0, pv1}, 3'b000);

    // ADD zero: pending one cycle, committed two edges later
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
    idle(1'b0); at_neg();
    check("add0_pend", {2'b0, pv1}, 3'b001);
    idle(1'b0); at_neg();
    check("add0_F", f1, 3'b100);
    check("add0_pend_clr", {2'b0, pv1}, 3'b000);

    // Build F=111, then XOR nonzero clears only Z
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h8000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 16'h0000, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); at_neg();
    check("F_111", f1, 3'b111);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 16'h0005, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); at_neg();
    check("xor_keeps_VN", f1, 3'b011);

    // Forwarding: F=100, then SUB and SLL in flight
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 16'hFFFF, 1'b1, 1'b1); at_neg();
    check("fwd_sub_Fid", fid1, 3'b011);
    check("fwd_sub_F_old", f1, 3'b100);
    check("nofwd_sub_stall", {2'b0, st0}, 3'b001);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 16'h0000, 1'b0, 1'b1); at_neg();
    check("fwd_sll_Fid", fid1, 3'b111);
    idle(1'b0); idle(1'b0);

    // No forwarding: two stall cycles then flags visible
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0005, 1'b0, 1'b1); at_neg();
    check("stall_c0", {2'b0, st0}, 3'b001);
    idle(1'b1); at_neg();
    check("stall_c1", {2'b0, st0}, 3'b001);
    idle(1'b1); at_neg();
    check("stall_c2", {2'b0, st0}, 3'b000);
    check("nofwd_Fid", fid0, 3'b000);
    idle(1'b0);

    // Flushed writer never commits
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
    idle(1'b0); at_neg();
    check("flush_pend", {2'b0, pv1}, 3'b000);
    idle(1'b0); at_neg();
    check("flush_F", f1, 3'b000);

    // Held capture: commit two unheld edges after release
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0); at_neg();
    check("hold_pend", {2'b0, pv1}, 3'b000);
    idle(1'b0); at_neg();
    check("hold_pend_after", {2'b0, pv1}, 3'b001);
    check("hold_F_old", f1, 3'b000);
    idle(1'b0); at_neg();
    check("hold_F_new", f1, 3'b100);

    // Reset drops a pending writer
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h8000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 16'h0, 1'b0, 1'b0);
    idle(1'b0); at_neg();
    check("rst_drop_F", f1, 3'b000);
    check("rst_drop_pend", {2'b0, pv1}, 3'b000);
    idle(1'b0); at_neg();
    check("rst_no_late_commit", f1, 3'b000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] res;
      int sel;
      sel = $urandom_range(0, 3);
      res = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h8000 : 16'($urandom);
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
           4'($urandom_range(0, 15)), res, $urandom_range(0, 1),
           $urandom_range(0, 1));
    end
    idle(1'b0);

    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    check("scoreboard_drained", (sb_q.size() == 0) ? 3'b001 : 3'b000, 3'b001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
